ft245_sync_emu: RTL and testbench
=================================

Name: ft245_sync_emu

Overview:
- Synthesizable emulator of the FT245 synchronous-FIFO device side: the peer the ft245 master talks to.
- Presents ft_rxf_n / ft_txe_n / bus data exactly as the USB chip does, so the FPGA-side master can be exercised on-chip or in simulation without silicon.
- Host side is two byte streams: host-to-device bytes queued for the master to read, and device-to-host bytes captured from master writes.
- Used in loopback benches and in board bring-up images.

Parameters:
- DEPTH_LOG2, 4, log2 of each internal buffer depth (16 bytes per direction).
- PKT_BYTES, 8, release threshold for device-to-host bytes; used only with FT245_EMU_SIWU_EN.

Ports:
- clk  in  1  emulated ft_clkout domain; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ft_data_in  in  8  bus value driven by the master (wr data).
- ft_data_out  out  8  bus value driven by the emulator (rd data).
- ft_data_oe  out  1  emulator bus drive enable; the top-level tristate uses it.
- ft_rxf_n  out  1  low = byte available for master to read.
- ft_txe_n  out  1  low = space for master to write.
- ft_rd_n  in  1  master read strobe.
- ft_wr_n  in  1  master write strobe.
- ft_oe_n  in  1  master output-enable request.
- ft_siwu_n  in  1  send-immediate / wake-up.
- host_wdata  in  8  byte to queue toward master.
- host_wvalid  in  1  push request.
- host_wready  out  1  rx buffer not full.
- host_rdata  out  8  byte captured from master.
- host_rvalid  out  1  captured byte available.
- host_rready  in  1  pop acknowledge.
- rd_err  out  1  sticky: read strobe seen while ft_rxf_n high.
- wr_err  out  1  sticky: write strobe seen while ft_txe_n high.

Behaviour:
- Reset values:
  - ft_rxf_n=1, ft_txe_n=1, rd_err=0, wr_err=0, host_rvalid=0, host_wready=1.
  - Both buffers empty; ft_data_out=8'h00.
- Two circular buffers of 2^DEPTH_LOG2 bytes with DEPTH_LOG2+1-bit occupancy counters. Pointers wrap naturally. Both buffers are first-word-fall-through.
- RX buffer (host to master):
  - Push on host_wvalid & host_wready. host_wready = (rx_count != DEPTH).
  - ft_data_out = RX head combinationally.
  - Pop on a rising edge with ft_rd_n==0 & ft_rxf_n==0.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - ft_rxf_n is a register; next value = (next rx_count == 0). It rises on the edge that consumes the last byte, and falls one cycle after the first push into an empty buffer.
  - Back-to-back reads at one byte per clock while strobe and rxf_n stay low.
- ft_data_oe = ~ft_oe_n (combinational). The emulator never drives the bus otherwise.
- TX buffer (master to host):
  - Write on a rising edge with ft_wr_n==0 & ft_txe_n==0; stores ft_data_in.
  - ft_txe_n is a register; next value = (next tx_count == DEPTH). It goes low on the first edge after reset release.
  - Overflow is impossible by construction.
  - host_rdata = TX head. host_rvalid = (tx_count != 0), subject to the optional feature. Pop on host_rvalid & host_rready.
  - Simultaneous write and pop keep the count.
- Error flags:
  - ft_rd_n==0 while ft_rxf_n==1 sets rd_err; the buffer is untouched.
  - ft_wr_n==0 while ft_txe_n==1 sets wr_err; the byte is dropped.
  - Both flags clear only on rst.
- ft_rd_n low while ft_oe_n high is legal. The pop still occurs; matching chip behaviour is the master's responsibility.
- rst asserted mid-burst: buffers empty immediately; rxf_n/txe_n go high asynchronously; any in-flight strobe is ignored.

Optional Feature:
- Macro: FT245_EMU_SIWU_EN.
- Without the macro:
  - ft_siwu_n is ignored.
  - host_rvalid = (tx_count != 0).
- With the macro:
  - Captured bytes are released in packets. host_rvalid = (tx_count != 0) & (release | tx_count >= PKT_BYTES).
  - ft_siwu_n sampled low sets release.
  - release clears when tx_count becomes 0, unless siwu_n is low on that edge.

Test Plan:
- Reset, then push 8'hD0..8'hD9 on the host side. Master asserts oe_n, then holds rd_n low → ten bytes D0..D9 read in order, one per clock. ft_rxf_n rises on the edge consuming D9. rd_err=0.
- Master writes 16 bytes 8'h00..8'h0F with host_rready=0 → ft_txe_n high on the edge after the 16th write. A 17th strobe sets wr_err=1 and does not change stored data. Draining returns 00..0F.
- Loopback: host pop output fed back to host push. Master reads D0..D9 and writes them back → host_rdata sequence D0..D9 with no loss.
- Simultaneous push and pop every cycle for 50 cycles with rx_count=3 → count stays 3, ft_rxf_n stays 0, data order preserved across pointer wrap.
- rd_n low with an empty buffer → rd_err=1, ft_rxf_n stays 1. rst pulse mid-burst → all flags and counts return to reset values.
- With FT245_EMU_SIWU_EN, PKT_BYTES=8:
  - Write 5 bytes → host_rvalid=0.
  - Pulse ft_siwu_n low → host_rvalid=1; all 5 bytes drain, then host_rvalid=0.
  - Write 8 bytes → host_rvalid=1 with no SIWU.

Source files
------------

// File: rtl/ft245_sync_emu.sv
// ft245_sync_emu: device-side emulator of the FT245 synchronous FIFO bus.
// Holds a host->master RX buffer and a master->host TX buffer, and presents
// ft_rxf_n / ft_txe_n / read data the way the USB bridge chip does.
// Optional build macro: FT245_EMU_SIWU_EN (packetised release of captured
// bytes, flushed early by ft_siwu_n).
module ft245_sync_emu #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PKT_BYTES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ft_data_in,
  output logic [7:0] ft_data_out,
  output logic       ft_data_oe,
  output logic       ft_rxf_n,
  output logic       ft_txe_n,
  input  logic       ft_rd_n,
  input  logic       ft_wr_n,
  input  logic       ft_oe_n,
  input  logic       ft_siwu_n,
  input  logic [7:0] host_wdata,
  input  logic       host_wvalid,
  output logic       host_wready,
  output logic [7:0] host_rdata,
  output logic       host_rvalid,
  input  logic       host_rready,
  output logic       rd_err,
  output logic       wr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [CW-1:0]         cnt_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t PKT_C   = cnt_t'(PKT_BYTES);

  logic [7:0] rx_mem [DEPTH];
  logic [7:0] tx_mem [DEPTH];

  ptr_t rx_wptr, rx_rptr, tx_wptr, tx_rptr;
  cnt_t rx_count, rx_count_nxt, tx_count, tx_count_nxt;

  logic rx_push, rx_pop, tx_wr, tx_pop;

  assign rx_push = host_wvalid & host_wready;
  assign rx_pop  = ~ft_rd_n & ~ft_rxf_n;
  assign tx_wr   = ~ft_wr_n & ~ft_txe_n;
  assign tx_pop  = host_rvalid & host_rready;

  assign host_wready = (rx_count != DEPTH_C);
  assign ft_data_oe  = ~ft_oe_n;

  // Head bytes fall through; an empty buffer presents zero instead of stale data
  assign ft_data_out = (rx_count != '0) ? rx_mem[rx_rptr] : 8'h00;
  assign host_rdata  = (tx_count != '0) ? tx_mem[tx_rptr] : 8'h00;

  // Next occupancy of both buffers; simultaneous push and pop cancel out
  always_comb begin
    rx_count_nxt = rx_count;
    tx_count_nxt = tx_count;
    if (rx_push && !rx_pop)
      rx_count_nxt = rx_count + cnt_t'(1);
    else if (!rx_push && rx_pop)
      rx_count_nxt = rx_count - cnt_t'(1);
    if (tx_wr && !tx_pop)
      tx_count_nxt = tx_count + cnt_t'(1);
    else if (!tx_wr && tx_pop)
      tx_count_nxt = tx_count - cnt_t'(1);
  end

  // Buffer storage carries no reset; occupancy counters decide validity
  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wptr] <= host_wdata;
    if (tx_wr)
      tx_mem[tx_wptr] <= ft_data_in;
  end

  // Pointers, counters and the registered bus status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      rx_count <= '0;
      tx_count <= '0;
      ft_rxf_n <= 1'b1;
      ft_txe_n <= 1'b1;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + ptr_t'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + ptr_t'(1);
      if (tx_wr)   tx_wptr <= tx_wptr + ptr_t'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + ptr_t'(1);
      rx_count <= rx_count_nxt;
      tx_count <= tx_count_nxt;
      ft_rxf_n <= (rx_count_nxt == '0);
      ft_txe_n <= (tx_count_nxt == DEPTH_C);
    end
  end

  // Sticky protocol-violation flags; the offending strobe has no other effect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_err <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      if (!ft_rd_n && ft_rxf_n) rd_err <= 1'b1;
      if (!ft_wr_n && ft_txe_n) wr_err <= 1'b1;
    end
  end

`ifdef FT245_EMU_SIWU_EN
  logic release_q;

  // SIWU latches an early release; it lapses once the TX buffer has emptied
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      release_q <= 1'b0;
    else if (!ft_siwu_n)
      release_q <= 1'b1;
    else if (tx_count_nxt == '0)
      release_q <= 1'b0;
  end

  assign host_rvalid = (tx_count != '0) & (release_q | (tx_count >= PKT_C));
`else
  logic unused_siwu;

  assign unused_siwu = ^{ft_siwu_n, PKT_C};
  assign host_rvalid = (tx_count != '0);
`endif

endmodule

// File: tb/tb_ft245_sync_emu.sv
// tb_ft245_sync_emu: directed bench for ft245_sync_emu (reads, writes,
// loopback, pointer wrap, error flags, async reset, optional SIWU release).
module tb_ft245_sync_emu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ft_data_in;
  logic [7:0] ft_data_out;
  logic       ft_data_oe;
  logic       ft_rxf_n;
  logic       ft_txe_n;
  logic       ft_rd_n;
  logic       ft_wr_n;
  logic       ft_oe_n;
  logic       ft_siwu_n;
  logic [7:0] host_wdata;
  logic       host_wvalid;
  logic       host_wready;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       host_rready;
  logic       rd_err;
  logic       wr_err;

  logic [7:0] drv_wdata;
  logic       drv_wvalid;
  logic       drv_rready;
  logic       lb;
  logic       mon_en;
  logic [7:0] mon_q [$];
  logic [7:0] cap;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Loopback mode ties the host pop stream straight back into the host push
  assign host_wdata  = lb ? host_rdata  : drv_wdata;
  assign host_wvalid = lb ? host_rvalid : drv_wvalid;
  assign host_rready = lb ? host_wready : drv_rready;

  ft245_sync_emu #(.DEPTH_LOG2(4), .PKT_BYTES(8)) dut (
    .clk(clk), .rst(rst),
    .ft_data_in(ft_data_in), .ft_data_out(ft_data_out), .ft_data_oe(ft_data_oe),
    .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
    .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .ft_oe_n(ft_oe_n), .ft_siwu_n(ft_siwu_n),
    .host_wdata(host_wdata), .host_wvalid(host_wvalid), .host_wready(host_wready),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_rready(host_rready),
    .rd_err(rd_err), .wr_err(wr_err)
  );

  // Record every byte the host side pops (handshake is stable at negedge)
  always @(negedge clk) begin
    if (mon_en && host_rvalid && host_rready)
      mon_q.push_back(host_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    ft_data_in = 8'h00;
    ft_rd_n = 1'b1; ft_wr_n = 1'b1; ft_oe_n = 1'b1; ft_siwu_n = 1'b1;
    drv_wdata = 8'h00; drv_wvalid = 1'b0; drv_rready = 1'b0;
    lb = 1'b0; mon_en = 1'b0; cap = 8'h00;

    // Reset state
    step();
    step();
    chk("rst_rxf_n", ft_rxf_n, 1);
    chk("rst_txe_n", ft_txe_n, 1);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_wready", host_wready, 1);
    chk("rst_data_out", ft_data_out, 8'h00);
    chk("rst_data_oe", ft_data_oe, 0);
    rst = 1'b0;
    step();
    chk("txe_after_release", ft_txe_n, 0);
    chk("rxf_after_release", ft_rxf_n, 1);

    // Host pushes D0..D9; master reads them back one per clock
    for (int i = 0; i < 10; i++) begin
      drv_wvalid = 1'b1;
      drv_wdata  = 8'hD0 + 8'(i);
      step();
      if (i == 0) chk("rxf_after_first_push", ft_rxf_n, 0);
    end
    drv_wvalid = 1'b0;
    ft_oe_n = 1'b0;
    #1;
    chk("data_oe_on", ft_data_oe, 1);
    for (int i = 0; i < 10; i++) begin
      ft_rd_n = 1'b0;
      #1;
      chk("rd_data", ft_data_out, 8'hD0 + 8'(i));
      chk("rd_rxf_n_low", ft_rxf_n, 0);
      step();
    end
    ft_rd_n = 1'b1;
    ft_oe_n = 1'b1;
    chk("rxf_after_d9", ft_rxf_n, 1);
    chk("rd_err_clean", rd_err, 0);

    // Master fills TX with 00..0F, overflows once, host drains
    drv_rready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("txe_low_while_writing", ft_txe_n, 0);
      ft_wr_n = 1'b0;
      ft_data_in = 8'(i);
      step();
    end
    chk("txe_full", ft_txe_n, 1);
    chk("rvalid_full", host_rvalid, 1);
    ft_data_in = 8'hAA;
    step();
    ft_wr_n = 1'b1;
    chk("wr_err_set", wr_err, 1);
    drv_rready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("drain_valid", host_rvalid, 1);
      chk("drain_data", host_rdata, 8'(i));
      step();
    end
    drv_rready = 1'b0;
    chk("drain_empty", host_rvalid, 0);
    chk("txe_after_drain", ft_txe_n, 0);
    chk("wr_err_sticky", wr_err, 1);

    // Loopback: master echoes each read byte back as a write
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drv_wvalid = 1'b1;
      drv_wdata  = 8'hD0 + 8'(i);
      step();
    end
    drv_wvalid = 1'b0;
`ifdef FT245_EMU_SIWU_EN
    ft_siwu_n = 1'b0;
`endif
    lb = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ft_rd_n = 1'b0;
      cap = ft_data_out;
      step();
      ft_rd_n = 1'b1;
      ft_wr_n = 1'b0;
      ft_data_in = cap;
      step();
      ft_wr_n = 1'b1;
    end
    for (int i = 0; i < 4; i++) step();
    mon_en = 1'b0;
    lb = 1'b0;
    ft_siwu_n = 1'b1;
    chk("lb_count", mon_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      cap = (i < mon_q.size()) ? mon_q[i] : 8'hXX;
      chk("lb_data", cap, 8'hD0 + 8'(i));
    end

    // Streaming push+pop with three bytes resident, across pointer wrap
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv_wvalid = 1'b1;
      drv_wdata  = 8'h40 + 8'(i);
      step();
    end
    for (int i = 0; i < 50; i++) begin
      drv_wvalid = 1'b1;
      drv_wdata  = 8'h43 + 8'(i);
      ft_rd_n = 1'b0;
      #1;
      chk("wrap_data", ft_data_out, 8'h40 + 8'(i));
      chk("wrap_rxf_n", ft_rxf_n, 0);
      step();
    end
    drv_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wrap_tail", ft_data_out, 8'h72 + 8'(i));
      chk("wrap_tail_rxf", ft_rxf_n, 0);
      step();
    end
    ft_rd_n = 1'b1;
    chk("wrap_empty_rxf", ft_rxf_n, 1);

    // Read of an empty buffer, RX full, then async reset mid-burst
    ft_rd_n = 1'b0;
    step();
    ft_rd_n = 1'b1;
    chk("rd_err_set", rd_err, 1);
    chk("rd_err_rxf", ft_rxf_n, 1);
    for (int i = 0; i < 16; i++) begin
      drv_wvalid = 1'b1;
      drv_wdata  = 8'h60 + 8'(i);
      step();
    end
    drv_wvalid = 1'b0;
    chk("rx_full_wready", host_wready, 0);
    ft_rd_n = 1'b0;
    ft_wr_n = 1'b0;
    ft_data_in = 8'h55;
    step();
    step();
    chk("burst_rvalid", host_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("arst_rxf_n", ft_rxf_n, 1);
    chk("arst_txe_n", ft_txe_n, 1);
    chk("arst_rd_err", rd_err, 0);
    chk("arst_wr_err", wr_err, 0);
    chk("arst_wready", host_wready, 1);
    chk("arst_rvalid", host_rvalid, 0);
    chk("arst_data_out", ft_data_out, 8'h00);
    step();
    ft_rd_n = 1'b1;
    ft_wr_n = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("post_arst_txe", ft_txe_n, 0);
    chk("post_arst_rxf", ft_rxf_n, 1);
    chk("post_arst_rvalid", host_rvalid, 0);

`ifdef FT245_EMU_SIWU_EN
    // Packetised release: below threshold held back until SIWU
    do_reset();
    drv_rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ft_wr_n = 1'b0;
      ft_data_in = 8'h80 + 8'(i);
      step();
    end
    ft_wr_n = 1'b1;
    step();
    chk("siwu_hold", host_rvalid, 0);
    ft_siwu_n = 1'b0;
    step();
    ft_siwu_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("siwu_valid", host_rvalid, 1);
      chk("siwu_data", host_rdata, 8'h80 + 8'(i));
      step();
    end
    chk("siwu_drained", host_rvalid, 0);
    drv_rready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ft_wr_n = 1'b0;
      ft_data_in = 8'h90 + 8'(i);
      step();
      if (i == 6) chk("pkt_below", host_rvalid, 0);
    end
    ft_wr_n = 1'b1;
    chk("pkt_release", host_rvalid, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
